// File: rtl/icache_line_fill.sv
// Line-fill engine: fetches one 4-word I-cache line critical-word-first with wrap,
// early-forwards the critical word and returns the packed line for a one-cycle write.
module icache_line_fill #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid,
  input  logic [WORD_SIZE-1:0]            req_addr,
  output logic                            req_ready,
  output logic                            mem_read,
  output logic [WORD_SIZE-1:0]            mem_addr,
  input  logic                            mem_ack,
  input  logic [WORD_SIZE-1:0]            mem_data,
  output logic                            crit_valid,
  output logic [WORD_SIZE-1:0]            crit_data,
  output logic                            fill_valid,
  output logic [WORD_SIZE-1:0]            fill_addr,
  output logic [LINE_WORDS*WORD_SIZE-1:0] fill_data,
  output logic [1:0]                      state_dbg
);

  // Handshakes: a request transfers on a clk edge with req_valid && req_ready; a memory
  // word transfers on a clk edge with mem_read && mem_ack; mem_read/mem_addr hold until then.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WORD_SIZE-3:0]            base_q;
  logic [1:0]                      off_q;
  logic [1:0]                      cnt_q;
  logic [1:0]                      slot;
  logic                            take;
  logic [WORD_SIZE-1:0]            line_q [LINE_WORDS];
  logic [LINE_WORDS*WORD_SIZE-1:0] line_merged;
  logic                            crit_valid_q;
  logic [WORD_SIZE-1:0]            crit_data_q;
  logic [WORD_SIZE-1:0]            fill_addr_q;
  logic [LINE_WORDS*WORD_SIZE-1:0] fill_data_q;

  // Two-bit add gives the wrap-around inside the line for free.
  assign slot = off_q + cnt_q;
  assign take = (state == FETCH) && mem_ack;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = FETCH;
      FETCH:   if (mem_ack && (cnt_q == 2'd3)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    mem_read   = (state == FETCH);
    fill_valid = (state == DONE);
    mem_addr   = {base_q, slot};
    state_dbg  = state;
    crit_valid = crit_valid_q;
    crit_data  = crit_data_q;
    fill_addr  = fill_addr_q;
    fill_data  = fill_data_q;
  end

  // Line as it will look after this edge, so the last word goes straight into fill_data.
  always_comb begin
    line_merged = '0;
    for (int k = 0; k < LINE_WORDS; k++) begin
      line_merged[k*WORD_SIZE +: WORD_SIZE] =
        (take && (slot == 2'(k))) ? mem_data : line_q[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q       <= '0;
      off_q        <= '0;
      cnt_q        <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      for (int k = 0; k < LINE_WORDS; k++) line_q[k] <= '0;
    end else begin
      crit_valid_q <= take && (cnt_q == 2'd0);
      if ((state == IDLE) && req_valid) begin
        base_q <= req_addr[WORD_SIZE-1:2];
        off_q  <= req_addr[1:0];
        cnt_q  <= 2'd0;
      end
      if (take) begin
        line_q[slot] <= mem_data;
        cnt_q        <= cnt_q + 2'd1;
        if (cnt_q == 2'd0) crit_data_q <= mem_data;
        if (cnt_q == 2'd3) begin
          fill_data_q <= line_merged;
          fill_addr_q <= {base_q, 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_icache_line_fill.sv
// Bench for icache_line_fill: directed vector table, back-to-back and reset-mid-fill
// sequences, then randomized traffic against a transaction-level reference model.
module tb_icache_line_fill;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic [W-1:0]  req_addr;
  logic          req_ready;
  logic          mem_read;
  logic [W-1:0]  mem_addr;
  logic          mem_ack;
  logic [W-1:0]  mem_data;
  logic          crit_valid;
  logic [W-1:0]  crit_data;
  logic          fill_valid;
  logic [W-1:0]  fill_addr;
  logic [4*W-1:0] fill_data;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  icache_line_fill #(.WORD_SIZE(W), .LINE_WORDS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .fill_valid (fill_valid),
    .fill_addr  (fill_addr),
    .fill_data  (fill_data),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic [W-1:0]   addr;
    int             period;
    logic [W-1:0]   crit;
    logic [W-1:0]   faddr;
    logic [4*W-1:0] fdata;
    int             fill_cyc;
  } vec_t;

  vec_t vecs[4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: expected memory reads of the open request, plus held outputs.
  logic [W-1:0]   exp_q[$];
  int             m_phase;      // 0 waiting for request, 1 reading words, 2 line pulse
  int             m_acks;
  bit             m_crit_pulse;
  logic [W-1:0]   m_req;
  logic [W-1:0]   m_crit_data;
  logic [W-1:0]   m_fill_addr;
  logic [4*W-1:0] m_fill_data;

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return 16'hA000 + a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = 0;
    m_acks       = 0;
    m_crit_pulse = 0;
    m_crit_data  = '0;
    m_fill_addr  = '0;
    m_fill_data  = '0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    check("req_ready", 64'(req_ready), 64'(m_phase == 0));
    check("mem_read", 64'(mem_read), 64'(m_phase == 1));
    if (m_phase == 1 && exp_q.size() > 0) check("mem_addr", 64'(mem_addr), 64'(exp_q[0]));
    check("crit_valid", 64'(crit_valid), 64'(m_crit_pulse));
    check("crit_data", 64'(crit_data), 64'(m_crit_data));
    check("fill_valid", 64'(fill_valid), 64'(m_phase == 2));
    check("fill_addr", 64'(fill_addr), 64'(m_fill_addr));
    check("fill_data", fill_data, m_fill_data);
  endtask

  task automatic check_reset_values();
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_mem_read", 64'(mem_read), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_crit_valid", 64'(crit_valid), 64'(0));
    check("rst_crit_data", 64'(crit_data), 64'(0));
    check("rst_fill_valid", 64'(fill_valid), 64'(0));
    check("rst_fill_addr", 64'(fill_addr), 64'(0));
    check("rst_fill_data", fill_data, 64'(0));
  endtask

  // One clock: drive inputs, advance the model across the edge, compare #1 after it.
  task automatic cycle(input bit rv, input logic [W-1:0] ra, input bit ack);
    logic [W-1:0] d;
    logic [W-1:0] base;
    int           off;
    d = 16'($urandom);
    if (m_phase == 1 && ack) d = mem_word(exp_q[0]);
    req_valid = rv;
    req_addr  = ra;
    mem_ack   = ack;
    mem_data  = d;
    @(posedge clk);
    cyc++;
    m_crit_pulse = 0;
    case (m_phase)
      0: if (rv) begin
        m_phase = 1;
        m_acks  = 0;
        m_req   = ra;
        base    = ra & 16'hFFFC;
        off     = int'(ra[1:0]);
        for (int i = 0; i < 4; i++) exp_q.push_back(base + 16'((off + i) % 4));
      end
      1: if (ack) begin
        if (m_acks == 0) begin
          m_crit_pulse = 1;
          m_crit_data  = d;
        end
        void'(exp_q.pop_front());
        m_acks++;
        if (m_acks == 4) begin
          m_phase     = 2;
          base        = m_req & 16'hFFFC;
          m_fill_addr = base;
          for (int k = 0; k < 4; k++) m_fill_data[k*W +: W] = mem_word(base + 16'(k));
        end
      end
      default: m_phase = 0;
    endcase
    #1;
    check_outputs();
  endtask

  task automatic reset_mid();
    #2;
    reset     = 1'b1;
    req_valid = 1'b0;
    mem_ack   = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
    check_outputs();
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int             crit_n;
    int             fill_n;
    int             fill_at;
    bit             done;
    logic [W-1:0]   crit_seen;
    logic [W-1:0]   faddr_seen;
    logic [4*W-1:0] fdata_seen;
    crit_n = 0; fill_n = 0; fill_at = -1; done = 0;
    crit_seen = '0; faddr_seen = '0; fdata_seen = '0;
    cycle(1'b1, v.addr, 1'b0);
    for (int j = 1; j <= 100 && !done; j++) begin
      cycle(1'b0, 16'h0, (j % v.period) == 0);
      if (crit_valid) begin
        crit_n++;
        crit_seen = crit_data;
      end
      if (fill_valid) begin
        fill_n++;
        fill_at    = j + 1;
        faddr_seen = fill_addr;
        fdata_seen = fill_data;
      end
      if (m_phase == 0) done = 1;
    end
    check({tag, "_finished"}, 64'(done), 64'(1));
    check({tag, "_crit_pulses"}, 64'(crit_n), 64'(1));
    check({tag, "_crit_word"}, 64'(crit_seen), 64'(v.crit));
    check({tag, "_fill_pulses"}, 64'(fill_n), 64'(1));
    check({tag, "_fill_cycle"}, 64'(fill_at), 64'(v.fill_cyc));
    check({tag, "_fill_addr"}, 64'(faddr_seen), 64'(v.faddr));
    check({tag, "_fill_line"}, fdata_seen, v.fdata);
  endtask

  initial begin
    int          a1;
    int          a2;
    int          pre;
    logic [W-1:0] ra;

    vecs[0] = '{addr: 16'h0040, period: 1, crit: 16'hA040, faddr: 16'h0040,
                fdata: 64'hA043_A042_A041_A040, fill_cyc: 5};
    vecs[1] = '{addr: 16'h1237, period: 1, crit: 16'hB237, faddr: 16'h1234,
                fdata: 64'hB237_B236_B235_B234, fill_cyc: 5};
    vecs[2] = '{addr: 16'h0022, period: 3, crit: 16'hA022, faddr: 16'h0020,
                fdata: 64'hA023_A022_A021_A020, fill_cyc: 13};
    vecs[3] = '{addr: 16'h0060, period: 1, crit: 16'hA060, faddr: 16'h0060,
                fdata: 64'hA063_A062_A061_A060, fill_cyc: 5};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    mem_ack   = 1'b0;
    mem_data  = '0;
    #1;
    check_reset_values();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Spurious acks while idle, then two requests with req_valid held throughout.
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1);
    a1 = -1;
    a2 = -1;
    ra = 16'h0010;
    for (int k = 0; k < 40 && a2 < 0; k++) begin
      pre = m_phase;
      cycle(1'b1, ra, 1'b1);
      if (pre == 0) begin
        if (a1 < 0) begin
          a1 = cyc;
          ra = 16'h0020;
        end else begin
          a2 = cyc;
        end
      end
    end
    check("b2b_period", 64'(a2 - a1), 64'(6));
    for (int k = 0; k < 20 && m_phase != 0; k++) cycle(1'b0, 16'h0, 1'b1);

    // Reset after the second word of a fill, then a clean fill.
    cycle(1'b1, 16'h0050, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    reset_mid();
    cycle(1'b0, 16'h0, 1'b1);
    run_vec(vecs[3], "after_reset");

    for (int n = 0; n < 40; n++) begin
      bit do_rst;
      int rst_at;
      ra = 16'($urandom);
      for (int k = 0; k < 50 && m_phase == 0; k++)
        cycle($urandom_range(0, 2) != 0, ra, $urandom_range(0, 3) == 0);
      do_rst = ($urandom_range(0, 7) == 0);
      rst_at = $urandom_range(1, 6);
      for (int k = 0; k < 300 && m_phase != 0; k++) begin
        if (do_rst && k == rst_at && m_phase == 1) reset_mid();
        else cycle($urandom_range(0, 1) == 1, 16'($urandom), $urandom_range(0, 1) == 1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
